smv_calc: RTL and testbench

Upstream stage of the fall-detection path. Takes one signed three-axis accelerometer sample (x, y, z) per handshake and computes the squared signal magnitude vector x²+y²+z² with a single iterative shift-add multiplier. Presents the result as a held 32-bit SMV_in-compatible word for the threshold/timing FSM downstream. Reports each update with a one-cycle pulse and flags samples dropped while busy.

---
 rtl/smv_calc.sv | 133 +++++++++++++
 tb/tb_smv_calc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/smv_calc.sv
// Squared signal magnitude x^2+y^2+z^2 of one signed 3-axis sample, computed
// with a single iterative shift-add multiplier (W+1 steps per axis).
module smv_calc #(
    parameter int unsigned W     = 12,
    parameter int unsigned OUT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] z_in,
    output logic [OUT_W-1:0]    SMV_out,
    output logic                smv_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned AccW = 2 * W + 1;
    localparam int unsigned BitW = $clog2(W + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(W);

    typedef enum logic [1:0] {StIdle, StSq, StDone} state_e;

    state_e           state_q, state_d;
    logic [W:0]       mag_x_q, mag_x_d, mag_y_q, mag_y_d, mag_z_q, mag_z_d;
    logic [1:0]       axis_q, axis_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0] smv_q, smv_d;
    logic             smv_valid_q, smv_valid_d;
    logic             overrun_q, overrun_d;
    logic [W:0]       cur_mag;
    logic [W:0]       cur_shr;

    // Magnitude in W+1 bits so the most negative sample stays exact.
    function automatic logic [W:0] abs_mag(input logic signed [W-1:0] v);
        logic [W:0] ext;
        ext = {v[W-1], v};
        return v[W-1] ? (~ext + (W+1)'(1)) : ext;
    endfunction

    always_comb begin
        cur_mag = mag_x_q;
        unique case (axis_q)
            2'd1:    cur_mag = mag_y_q;
            2'd2:    cur_mag = mag_z_q;
            default: cur_mag = mag_x_q;
        endcase
        cur_shr = cur_mag >> bit_q;
    end

    always_comb begin
        state_d     = state_q;
        mag_x_d     = mag_x_q;
        mag_y_d     = mag_y_q;
        mag_z_d     = mag_z_q;
        axis_d      = axis_q;
        bit_d       = bit_q;
        acc_d       = acc_q;
        smv_d       = smv_q;
        smv_valid_d = 1'b0;
        overrun_d   = overrun_q | (sample_valid && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    mag_x_d = abs_mag(x_in);
                    mag_y_d = abs_mag(y_in);
                    mag_z_d = abs_mag(z_in);
                    acc_d   = '0;
                    axis_d  = 2'd0;
                    bit_d   = '0;
                    state_d = StSq;
                end
            end
            StSq: begin
                if (cur_shr[0]) begin
                    acc_d = acc_q + (AccW'(cur_mag) << bit_q);
                end
                if (bit_q == LastBit) begin
                    bit_d = '0;
                    if (axis_q == 2'd2) begin
                        axis_d  = 2'd0;
                        state_d = StDone;
                    end else begin
                        axis_d = axis_q + 2'd1;
                    end
                end else begin
                    bit_d = bit_q + BitW'(1);
                end
            end
            StDone: begin
                smv_d       = OUT_W'(acc_q);
                smv_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mag_x_q     <= '0;
            mag_y_q     <= '0;
            mag_z_q     <= '0;
            axis_q      <= 2'd0;
            bit_q       <= '0;
            acc_q       <= '0;
            smv_q       <= '0;
            smv_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_x_q     <= mag_x_d;
            mag_y_q     <= mag_y_d;
            mag_z_q     <= mag_z_d;
            axis_q      <= axis_d;
            bit_q       <= bit_d;
            acc_q       <= acc_d;
            smv_q       <= smv_d;
            smv_valid_q <= smv_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign SMV_out   = smv_q;
    assign smv_valid = smv_valid_q;
    assign busy      = (state_q != StIdle);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_smv_calc.sv
// Self-checking bench for smv_calc: directed table, multi-cycle corner cases
// and randomized samples against an arithmetic reference.
module tb_smv_calc;

    logic               clk;
    logic               reset;
    logic               sample_valid;
    logic signed [11:0] x_in, y_in, z_in;
    logic [31:0]        SMV_out;
    logic               smv_valid;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    smv_calc #(.W(12), .OUT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .SMV_out      (SMV_out),
        .smv_valid    (smv_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (smv_valid) pulses++;

    typedef struct {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic signed [11:0] z;
        longint             exp;
    } vec_t;

    vec_t tbl[7];

    function automatic longint ref_smv(input logic signed [11:0] x, input logic signed [11:0] y,
                                       input logic signed [11:0] z);
        longint a, b, c;
        a = longint'(x);
        b = longint'(y);
        c = longint'(z);
        return a * a + b * b + c * c;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one edge, then wait (bounded) for the result pulse.
    task automatic send(input logic signed [11:0] x, input logic signed [11:0] y,
                        input logic signed [11:0] z, output int lat);
        sample_valid = 1'b1;
        x_in = x;
        y_in = y;
        z_in = z;
        tick();
        sample_valid = 1'b0;
        x_in = $urandom;
        y_in = $urandom;
        z_in = $urandom;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (smv_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int changed;
        longint held;
        longint first_exp;
        longint q[$];
        logic signed [11:0] rx, ry, rz;

        tbl[0] = '{12'sd3, -12'sd4, 12'sd12, 169};
        tbl[1] = '{12'h800, 12'h800, 12'h800, 12582912};
        tbl[2] = '{12'sd2047, 12'sd0, 12'sd0, 4190209};
        tbl[3] = '{12'sd0, 12'sd0, 12'sd0, 0};
        tbl[4] = '{-12'sd1, 12'sd1, -12'sd1, 3};
        tbl[5] = '{12'sd100, -12'sd200, 12'sd300, 140000};
        tbl[6] = '{12'h800, 12'sd2047, 12'sd0, 8384513};

        reset = 1'b0;
        sample_valid = 1'b0;
        x_in = '0;
        y_in = '0;
        z_in = '0;
        tick();
        tick();
        chk("reset_smv", SMV_out, 0);
        chk("reset_valid", smv_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        reset = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].z, lat);
            chk($sformatf("tbl%0d_latency", i), lat, 40);
            chk($sformatf("tbl%0d_smv", i), SMV_out, tbl[i].exp);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
            if (i == 0) begin
                held = SMV_out;
                changed = 0;
                cnt = 0;
                for (int k = 0; k < 100; k++) begin
                    tick();
                    if (longint'(SMV_out) != held) changed++;
                    if (smv_valid) cnt++;
                end
                chk("hold_smv_changes", changed, 0);
                chk("hold_extra_pulses", cnt, 0);
            end
        end

        // Overrun: pulses at E+10 and E+40 ignored, then accept at E+41
        first_exp = ref_smv(12'sd55, -12'sd66, 12'sd77);
        sample_valid = 1'b1;
        x_in = 12'sd55;
        y_in = -12'sd66;
        z_in = 12'sd77;
        tick();
        chk("ovr_busy_after_accept", busy, 1);
        for (int k = 1; k <= 40; k++) begin
            sample_valid = (k == 10 || k == 40);
            x_in = 12'sd1000;
            y_in = 12'sd1000;
            z_in = 12'sd1000;
            tick();
            if (k == 9) chk("ovr_before", overrun, 0);
            if (k == 10) chk("ovr_set", overrun, 1);
            if (k == 39) chk("ovr_no_early_valid", smv_valid, 0);
        end
        sample_valid = 1'b0;
        chk("ovr_valid_at_40", smv_valid, 1);
        chk("ovr_first_result", SMV_out, first_exp);
        send(-12'sd5, 12'sd6, -12'sd7, lat);
        chk("ovr_next_latency", lat, 40);
        chk("ovr_next_result", SMV_out, 110);
        chk("ovr_sticky", overrun, 1);

        // Reset mid-computation aborts the sample
        sample_valid = 1'b1;
        x_in = 12'sd9;
        y_in = 12'sd9;
        z_in = 12'sd9;
        tick();
        sample_valid = 1'b0;
        repeat (19) tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        tick();
        reset = 1'b1;
        cnt = pulses;
        repeat (50) tick();
        chk("midrst_no_pulse", pulses - cnt, 0);
        chk("midrst_smv", SMV_out, 0);
        chk("midrst_busy_after", busy, 0);
        chk("midrst_overrun", overrun, 0);

        // sample_valid held high: accepts every 41 cycles
        cnt = 0;
        for (int c = 0; c < 41 * 10; c++) begin
            rx = $urandom;
            ry = $urandom;
            rz = $urandom;
            sample_valid = 1'b1;
            x_in = rx;
            y_in = ry;
            z_in = rz;
            tick();
            if (c % 41 == 0) q.push_back(ref_smv(rx, ry, rz));
            if (smv_valid) begin
                cnt++;
                chk("cont_phase", c % 41, 40);
                if (q.size() > 0) chk("cont_smv", SMV_out, q.pop_front());
                else chk("cont_unexpected_pulse", 1, 0);
            end
        end
        sample_valid = 1'b0;
        chk("cont_count", cnt, 10);
        chk("cont_leftover", q.size(), 0);
        tick();

        // Random samples
        cnt = pulses;
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            ry = $urandom;
            rz = $urandom;
            if (i % 50 == 0) begin
                rx = 12'h800;
                rz = 12'h7ff;
            end
            send(rx, ry, rz, lat);
            chk("rand_latency", lat, 40);
            chk("rand_smv", SMV_out, ref_smv(rx, ry, rz));
        end
        tick();
        chk("rand_pulse_count", pulses - cnt, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
